// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - SPI frame field positions and FSM states shared by target and initiator
package spi_pkg;
   localparam int RW_BIT   = 7;
   localparam int MB_BIT   = 6;
   localparam int ADDR_MSB = 5;
   localparam logic [ADDR_MSB:0] DEVID_ADDR = 6'h00;

   typedef enum logic [1:0] {IDLE, CMD, DATA} spi_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-flop synchronizer with rise/fall detect on the synchronized level
module spi_sync_edge #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);
   logic [2:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sync_q <= {3{RESET_VAL}};
      else         sync_q <= {sync_q[1:0], d_i};
   end

   assign q_o    = sync_q[1];
   assign rise_o = sync_q[1] & ~sync_q[2];
   assign fall_o = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/adxl_spi_target.sv
// rtl/adxl_spi_target.sv - mode-3 SPI responder modelling the ADXL345 register file
module adxl_spi_target
   import spi_pkg::*;
#(
   parameter logic [7:0] DEVID = 8'hE5
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       spi_cs_ni,
   input  logic       spi_clk_i,
   input  logic       spi_data_i,
   output logic       spi_data_o,
   output logic       spi_oe_o,
   input  logic       loc_we_i,
   input  logic [5:0] loc_addr_i,
   input  logic [7:0] loc_wdata_i,
   output logic [7:0] loc_rdata_o,
   output logic       wr_valid_o,
   output logic [5:0] wr_addr_o,
   output logic [7:0] wr_data_o,
   output logic       frame_err_o
);
   logic cs_q, sclk_rise, sclk_fall, mosi_q;
   logic cs_rise_unused, cs_fall_unused, mosi_rise_unused, mosi_fall_unused, sclk_lvl_unused;

   spi_sync_edge #(.RESET_VAL(1'b1)) u_cs (
      .clk_i(clk_i), .rst_ni(rst_ni), .d_i(spi_cs_ni),
      .q_o(cs_q), .rise_o(cs_rise_unused), .fall_o(cs_fall_unused));
   spi_sync_edge #(.RESET_VAL(1'b1)) u_sclk (
      .clk_i(clk_i), .rst_ni(rst_ni), .d_i(spi_clk_i),
      .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall));
   spi_sync_edge #(.RESET_VAL(1'b0)) u_mosi (
      .clk_i(clk_i), .rst_ni(rst_ni), .d_i(spi_data_i),
      .q_o(mosi_q), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused));

   spi_state_e state_q, state_d;
   logic [2:0] bit_cnt_q;
   logic [7:0] rx_sh_q, tx_sh_q, rx_byte, cmd_rd, inc_rd;
   logic [5:0] addr_q, addr_inc;
   logic       rw_q, mb_q, active_q, data_seen_q, oe_q;
   logic       cmd_done, byte_done, commit, frame_err_d;
   logic [7:0] regs_q [64];

   assign rx_byte     = {rx_sh_q[6:0], mosi_q};
   assign addr_inc    = addr_q + 6'd1;
   assign cmd_rd      = (rx_byte[ADDR_MSB:0] == DEVID_ADDR) ? DEVID : regs_q[rx_byte[ADDR_MSB:0]];
   assign inc_rd      = (addr_inc == DEVID_ADDR) ? DEVID : regs_q[addr_inc];
   assign loc_rdata_o = (loc_addr_i == DEVID_ADDR) ? DEVID : regs_q[loc_addr_i];

   always_comb begin
      state_d     = state_q;
      cmd_done    = 1'b0;
      byte_done   = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: if (!cs_q) state_d = CMD;
         CMD: begin
            if (cs_q) begin
               state_d     = IDLE;
               frame_err_d = 1'b1;
            end else if (sclk_rise && bit_cnt_q == 3'd7) begin
               state_d  = DATA;
               cmd_done = 1'b1;
            end
         end
         DATA: begin
            if (cs_q) begin
               state_d     = IDLE;
               frame_err_d = (bit_cnt_q != 3'd0) || !data_seen_q;
            end else if (sclk_rise && bit_cnt_q == 3'd7) begin
               byte_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bytes after a non-burst first byte and writes to DEVID are dropped here
   assign commit = byte_done && !rw_q && active_q && (addr_q != DEVID_ADDR);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         bit_cnt_q   <= 3'd0;
         rx_sh_q     <= 8'h00;
         tx_sh_q     <= 8'hFF;
         rw_q        <= 1'b0;
         mb_q        <= 1'b0;
         addr_q      <= 6'h00;
         active_q    <= 1'b0;
         data_seen_q <= 1'b0;
         oe_q        <= 1'b0;
         wr_valid_o  <= 1'b0;
         wr_addr_o   <= 6'h00;
         wr_data_o   <= 8'h00;
         frame_err_o <= 1'b0;
      end else begin
         state_q     <= state_d;
         frame_err_o <= frame_err_d;
         wr_valid_o  <= commit;
         if (commit) begin
            wr_addr_o <= addr_q;
            wr_data_o <= rx_byte;
         end
         if (state_q == IDLE) begin
            bit_cnt_q <= 3'd0;
         end else if (sclk_rise) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            rx_sh_q   <= rx_byte;
         end
         if (cs_q || state_q != DATA) oe_q <= 1'b0;
         else if (sclk_fall && rw_q)  oe_q <= 1'b1;
         if (cmd_done) begin
            rw_q        <= rx_byte[RW_BIT];
            mb_q        <= rx_byte[MB_BIT];
            addr_q      <= rx_byte[ADDR_MSB:0];
            active_q    <= 1'b1;
            data_seen_q <= 1'b0;
            tx_sh_q     <= rx_byte[RW_BIT] ? cmd_rd : 8'hFF;
         end else if (byte_done) begin
            data_seen_q <= 1'b1;
            if (active_q && mb_q) begin
               addr_q  <= addr_inc;
               tx_sh_q <= inc_rd;
            end else begin
               active_q <= 1'b0;
               tx_sh_q  <= 8'hFF;
            end
         end else if (state_q == DATA && sclk_fall && bit_cnt_q != 3'd0) begin
            // First fall of each byte presents bit 7 already loaded; later falls shift
            tx_sh_q <= {tx_sh_q[6:0], 1'b1};
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 64; i++) regs_q[i] <= 8'h00;
      end else begin
         if (loc_we_i && loc_addr_i != DEVID_ADDR) regs_q[loc_addr_i] <= loc_wdata_i;
         // Placed last so an SPI commit overrides a local write to the same address
         if (commit) regs_q[addr_q] <= rx_byte;
      end
   end

   assign spi_oe_o   = oe_q;
   assign spi_data_o = oe_q & tx_sh_q[7];
endmodule

// File: tb/tb_adxl_spi_target.sv
// tb/tb_adxl_spi_target.sv - scoreboard bench for adxl_spi_target
module tb_adxl_spi_target;
   logic       clk_i = 1'b0, rst_ni = 1'b0;
   logic       spi_cs_ni = 1'b1, spi_clk_i = 1'b1, spi_data_i = 1'b0;
   logic       loc_we_i = 1'b0;
   logic [5:0] loc_addr_i = 6'h00;
   logic [7:0] loc_wdata_i = 8'h00;
   logic       spi_data_o, spi_oe_o, wr_valid_o, frame_err_o;
   logic [5:0] wr_addr_o;
   logic [7:0] wr_data_o, loc_rdata_o;

   int          checks = 0, errors = 0, fe_cnt = 0, oe_bad = 0;
   logic [7:0]  exp_rd [$];
   logic [13:0] exp_wr [$], obs_wr [$];
   logic [7:0]  mdl [64];
   logic [7:0]  tx_b [8], rx_b [8];
   logic [7:0]  e8;
   logic [13:0] e14, o14;

   always #5 clk_i = ~clk_i;

   adxl_spi_target dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .spi_cs_ni(spi_cs_ni), .spi_clk_i(spi_clk_i),
      .spi_data_i(spi_data_i), .spi_data_o(spi_data_o), .spi_oe_o(spi_oe_o),
      .loc_we_i(loc_we_i), .loc_addr_i(loc_addr_i), .loc_wdata_i(loc_wdata_i),
      .loc_rdata_o(loc_rdata_o), .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o),
      .wr_data_o(wr_data_o), .frame_err_o(frame_err_o));

   always @(negedge clk_i) begin
      if (wr_valid_o)  obs_wr.push_back({wr_addr_o, wr_data_o});
      if (frame_err_o) fe_cnt++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   // SCLK period is 8 clk_i; MISO is captured just before each rise
   task automatic spi_frame(input int nbits, input logic rd, input logic coll,
                            input logic [5:0] c_addr, input logic [7:0] c_data);
      oe_bad = 0;
      for (int k = 0; k < 8; k++) rx_b[k] = 8'h00;
      @(negedge clk_i);
      spi_cs_ni = 1'b0;
      wait_clk(4);
      for (int i = 0; i < nbits; i++) begin
         spi_clk_i  = 1'b0;
         spi_data_i = tx_b[i / 8][7 - (i % 8)];
         wait_clk(4);
         if (spi_oe_o !== ((i >= 8) ? rd : 1'b0)) oe_bad++;
         rx_b[i / 8] = {rx_b[i / 8][6:0], spi_data_o};
         spi_clk_i = 1'b1;
         if (coll && i == nbits - 1) begin
            loc_we_i = 1'b1; loc_addr_i = c_addr; loc_wdata_i = c_data;
         end
         for (int w = 0; w < 4; w++) begin
            @(negedge clk_i);
            if (loc_we_i && wr_valid_o) loc_we_i = 1'b0;
         end
      end
      loc_we_i  = 1'b0;
      spi_cs_ni = 1'b1;
      wait_clk(8);
      if (spi_oe_o !== 1'b0 || spi_data_o !== 1'b0) oe_bad++;
   endtask

   task automatic test_reset();
      wait_clk(1);
      checks++;
      if ({spi_oe_o, spi_data_o, wr_valid_o, frame_err_o, wr_addr_o, wr_data_o} !== 18'h0) begin
         errors++;
         $display("FAIL reset_outputs got %h exp 0", {spi_oe_o, spi_data_o, wr_valid_o, frame_err_o, wr_addr_o, wr_data_o});
      end
      loc_addr_i = 6'h00; #1;
      checks++;
      if (loc_rdata_o !== 8'hE5) begin errors++; $display("FAIL reset_devid got %h exp e5", loc_rdata_o); end
      loc_addr_i = 6'h2D; #1;
      checks++;
      if (loc_rdata_o !== 8'h00) begin errors++; $display("FAIL reset_reg2d got %h exp 00", loc_rdata_o); end
   endtask

   task automatic test_devid_read();
      tx_b = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      exp_rd.push_back(mdl[0]);
      spi_frame(16, 1'b1, 1'b0, 6'h00, 8'h00);
      e8 = exp_rd.pop_front();
      checks++;
      if (rx_b[1] !== e8) begin errors++; $display("FAIL devid_miso got %h exp %h", rx_b[1], e8); end
      checks++;
      if (oe_bad !== 0) begin errors++; $display("FAIL devid_oe got %0d bad samples exp 0", oe_bad); end
      checks++;
      if (obs_wr.size() != 0) begin errors++; $display("FAIL devid_no_wr got %0d pulses exp 0", obs_wr.size()); end
      obs_wr.delete();
   endtask

   task automatic test_write_read();
      tx_b = '{8'h2D, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      exp_wr.push_back({6'h2D, 8'h08}); mdl[6'h2D] = 8'h08;
      spi_frame(16, 1'b0, 1'b0, 6'h00, 8'h00);
      checks++;
      if (obs_wr.size() != exp_wr.size()) begin errors++; $display("FAIL wr_count got %0d exp %0d", obs_wr.size(), exp_wr.size()); end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         e14 = exp_wr.pop_front(); o14 = obs_wr.pop_front(); checks++;
         if (o14 !== e14) begin errors++; $display("FAIL wr_event got %h exp %h", o14, e14); end
      end
      exp_wr.delete(); obs_wr.delete();
      tx_b[0] = 8'hAD; tx_b[1] = 8'h00;
      exp_rd.push_back(mdl[6'h2D]);
      spi_frame(16, 1'b1, 1'b0, 6'h00, 8'h00);
      e8 = exp_rd.pop_front();
      checks++;
      if (rx_b[1] !== e8) begin errors++; $display("FAIL rd_2d got %h exp %h", rx_b[1], e8); end
      loc_addr_i = 6'h2D; #1;
      checks++;
      if (loc_rdata_o !== mdl[6'h2D]) begin errors++; $display("FAIL loc_2d got %h exp %h", loc_rdata_o, mdl[6'h2D]); end
   endtask

   task automatic test_burst_read();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk_i);
         loc_we_i = 1'b1; loc_addr_i = 6'(6'h32 + k); loc_wdata_i = 8'((k + 1) * 17);
         mdl[6'h32 + k] = 8'((k + 1) * 17);
      end
      @(negedge clk_i); loc_we_i = 1'b0;
      tx_b = '{8'hF2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      for (int k = 0; k < 6; k++) exp_rd.push_back(mdl[6'h32 + k]);
      spi_frame(56, 1'b1, 1'b0, 6'h00, 8'h00);
      for (int k = 1; k <= 6; k++) begin
         e8 = exp_rd.pop_front(); checks++;
         if (rx_b[k] !== e8) begin errors++; $display("FAIL burst_rd[%0d] got %h exp %h", k, rx_b[k], e8); end
      end
      checks++;
      if (oe_bad !== 0) begin errors++; $display("FAIL burst_oe got %0d bad samples exp 0", oe_bad); end
      tx_b[0] = 8'hB2;
      exp_rd.push_back(mdl[6'h32]); exp_rd.push_back(8'hFF);
      spi_frame(24, 1'b1, 1'b0, 6'h00, 8'h00);
      for (int k = 1; k <= 2; k++) begin
         e8 = exp_rd.pop_front(); checks++;
         if (rx_b[k] !== e8) begin errors++; $display("FAIL single_rd[%0d] got %h exp %h", k, rx_b[k], e8); end
      end
   endtask

   task automatic test_burst_write_wrap();
      tx_b = '{8'h7F, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      exp_wr.push_back({6'h3F, 8'hAA}); mdl[6'h3F] = 8'hAA;
      spi_frame(24, 1'b0, 1'b0, 6'h00, 8'h00);
      tx_b = '{8'h10, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      exp_wr.push_back({6'h10, 8'h01}); mdl[6'h10] = 8'h01;
      spi_frame(24, 1'b0, 1'b0, 6'h00, 8'h00);
      checks++;
      if (obs_wr.size() != exp_wr.size()) begin errors++; $display("FAIL wrap_wr_count got %0d exp %0d", obs_wr.size(), exp_wr.size()); end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         e14 = exp_wr.pop_front(); o14 = obs_wr.pop_front(); checks++;
         if (o14 !== e14) begin errors++; $display("FAIL wrap_wr_event got %h exp %h", o14, e14); end
      end
      exp_wr.delete(); obs_wr.delete();
      tx_b[0] = 8'h80; tx_b[1] = 8'h00;
      exp_rd.push_back(8'hE5);
      spi_frame(16, 1'b1, 1'b0, 6'h00, 8'h00);
      e8 = exp_rd.pop_front(); checks++;
      if (rx_b[1] !== e8) begin errors++; $display("FAIL wrap_devid got %h exp %h", rx_b[1], e8); end
      for (int k = 0; k < 3; k++) begin
         loc_addr_i = (k == 0) ? 6'h3F : ((k == 1) ? 6'h10 : 6'h11); #1;
         checks++;
         if (loc_rdata_o !== mdl[loc_addr_i]) begin
            errors++; $display("FAIL wrap_loc[%h] got %h exp %h", loc_addr_i, loc_rdata_o, mdl[loc_addr_i]);
         end
      end
   endtask

   task automatic test_frame_err();
      int fe0;
      fe0 = fe_cnt;
      tx_b = '{8'h31, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      spi_frame(10, 1'b0, 1'b0, 6'h00, 8'h00);
      checks++;
      if (fe_cnt !== fe0 + 1) begin errors++; $display("FAIL ferr_pulse got %0d exp %0d", fe_cnt - fe0, 1); end
      checks++;
      if (obs_wr.size() != 0) begin errors++; $display("FAIL ferr_no_wr got %0d pulses exp 0", obs_wr.size()); end
      obs_wr.delete();
      loc_addr_i = 6'h31; #1;
      checks++;
      if (loc_rdata_o !== mdl[6'h31]) begin errors++; $display("FAIL ferr_reg31 got %h exp %h", loc_rdata_o, mdl[6'h31]); end
      tx_b[0] = 8'hAD; tx_b[1] = 8'h00;
      exp_rd.push_back(mdl[6'h2D]);
      spi_frame(16, 1'b1, 1'b0, 6'h00, 8'h00);
      e8 = exp_rd.pop_front(); checks++;
      if (rx_b[1] !== e8) begin errors++; $display("FAIL ferr_recover got %h exp %h", rx_b[1], e8); end
   endtask

   task automatic test_collision();
      tx_b = '{8'h20, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      exp_wr.push_back({6'h20, 8'h33}); mdl[6'h20] = 8'h33;
      spi_frame(16, 1'b0, 1'b1, 6'h20, 8'h55);
      tx_b[0] = 8'h22; tx_b[1] = 8'h44;
      exp_wr.push_back({6'h22, 8'h44}); mdl[6'h22] = 8'h44; mdl[6'h21] = 8'h77;
      spi_frame(16, 1'b0, 1'b1, 6'h21, 8'h77);
      checks++;
      if (obs_wr.size() != exp_wr.size()) begin errors++; $display("FAIL coll_wr_count got %0d exp %0d", obs_wr.size(), exp_wr.size()); end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         e14 = exp_wr.pop_front(); o14 = obs_wr.pop_front(); checks++;
         if (o14 !== e14) begin errors++; $display("FAIL coll_wr_event got %h exp %h", o14, e14); end
      end
      exp_wr.delete(); obs_wr.delete();
      for (int k = 0; k < 3; k++) begin
         loc_addr_i = 6'(6'h20 + k); #1;
         checks++;
         if (loc_rdata_o !== mdl[loc_addr_i]) begin
            errors++; $display("FAIL coll_loc[%h] got %h exp %h", loc_addr_i, loc_rdata_o, mdl[loc_addr_i]);
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 64; k++) mdl[k] = 8'h00;
      mdl[0] = 8'hE5;
      wait_clk(3);
      rst_ni = 1'b1;
      test_reset();
      test_devid_read();
      test_write_read();
      test_burst_read();
      test_burst_write_wrap();
      test_frame_err();
      test_collision();
      checks++;
      if (fe_cnt !== 1) begin errors++; $display("FAIL total_frame_err got %0d exp 1", fe_cnt); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
